// File: rtl/lsu_pkg.sv
// Shared size codes, FSM states, RV32I load/store funct3 values and helpers for the LSU.
package lsu_pkg;

    localparam int XLEN_WIDTH = 32;
    localparam int REG_ADDR   = 5;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10
    } lsu_size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    localparam logic [2:0] INST_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] INST_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] INST_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] INST_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] INST_FUNCT3_LHU = 3'b101;
    localparam logic [2:0] INST_FUNCT3_SB  = 3'b000;
    localparam logic [2:0] INST_FUNCT3_SH  = 3'b001;
    localparam logic [2:0] INST_FUNCT3_SW  = 3'b010;

    // funct3[1:0] = 11 is treated as a word access
    function automatic lsu_size_e decode_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return LSU_SIZE_B;
            2'b01:   return LSU_SIZE_H;
            default: return LSU_SIZE_W;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            LSU_SIZE_B: return 4'b0001;
            LSU_SIZE_H: return 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    // Only accesses that spill past lane 3 need a second word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == LSU_SIZE_H) && (offset == 2'd3)) ||
               ((size == LSU_SIZE_W) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store strobes/data split over a lower and upper word, and load
// byte extraction from a {upper, lower} word pair with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  we_lo,
    output logic [3:0]  we_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);

    logic [7:0]  mask8;
    logic [63:0] st_wide;
    logic [63:0] ld_wide;
    logic [31:0] ld_raw;

    // Shift mask and data across an 8-lane window; the top four lanes belong to the upper word
    always_comb begin
        mask8    = {4'b0000, size_mask(st_size)} << st_off;
        st_wide  = {32'h0, st_data} << {st_off, 3'b000};
        we_lo    = mask8[3:0];
        we_hi    = mask8[7:4];
        wdata_lo = st_wide[31:0];
        wdata_hi = st_wide[63:32];
    end

    // Bring the addressed byte to lane 0, then extend to the access size
    always_comb begin
        ld_wide = {ld_hi, ld_lo} >> {ld_off, 3'b000};
        ld_raw  = ld_wide[31:0];
        case (ld_size)
            LSU_SIZE_B: ld_data = {{24{~ld_unsigned & ld_raw[7]}},  ld_raw[7:0]};
            LSU_SIZE_H: ld_data = {{16{~ld_unsigned & ld_raw[15]}}, ld_raw[15:0]};
            default:    ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte/half/word requests to a word-wide synchronous SRAM,
// splitting misaligned accesses into two consecutive word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_WIDTH,
    parameter int REG_AW = REG_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read_en,
    input  logic              req_write_en,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_write_data,
    input  logic [2:0]        req_funct3,
    input  logic [REG_AW-1:0] req_rd,
    output logic              stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              load_valid,
    output logic [REG_AW-1:0] load_rd,
    output logic [XLEN-1:0]   load_data
);

    lsu_state_e        state;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_data;
    logic [2:0]        lat_funct3;
    logic [REG_AW-1:0] lat_rd;
    logic              lat_load;

    logic [1:0]        resp_off;
    logic [1:0]        resp_size;
    logic              resp_unsigned;
    logic              resp_split;
    logic [XLEN-1:0]   lo_word;

    logic              in_second;
    logic              req_any;
    logic [1:0]        req_size;
    logic              req_mis;
    logic [1:0]        st_off;
    logic [1:0]        st_size;
    logic [XLEN-1:0]   st_data;
    logic [3:0]        we_lo;
    logic [3:0]        we_hi;
    logic [XLEN-1:0]   wdata_lo;
    logic [XLEN-1:0]   wdata_hi;
    logic [XLEN-1:0]   ld_lo;
    logic [XLEN-1:0]   ld_ext;

    // Request decode and alignment-input selection (live request in IDLE, latches in SECOND)
    always_comb begin
        in_second = (state == ST_SECOND);
        req_any   = req_read_en | req_write_en;
        req_size  = decode_size(req_funct3);
        req_mis   = is_misaligned(req_size, req_addr[1:0]);
        st_off    = in_second ? lat_addr[1:0] : req_addr[1:0];
        st_size   = in_second ? decode_size(lat_funct3) : req_size;
        st_data   = in_second ? lat_data : req_write_data;
        ld_lo     = resp_split ? lo_word : mem_rdata;
    end

    lsu_align u_align (
        .st_off      (st_off),
        .st_size     (st_size),
        .st_data     (st_data),
        .we_lo       (we_lo),
        .we_hi       (we_hi),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .ld_off      (resp_off),
        .ld_size     (resp_size),
        .ld_unsigned (resp_unsigned),
        .ld_lo       (ld_lo),
        .ld_hi       (mem_rdata),
        .ld_data     (ld_ext)
    );

    // SRAM port drive; held quiet while in reset so a pending upper half is dropped
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = rst_n & in_second;
        if (rst_n) begin
            if (in_second) begin
                mem_en   = 1'b1;
                mem_addr = {lat_addr[XLEN-1:2], 2'b00} + 32'd4;
                if (!lat_load) begin
                    mem_we    = we_hi;
                    mem_wdata = wdata_hi;
                end
            end else if (req_any) begin
                mem_en   = 1'b1;
                mem_addr = {req_addr[XLEN-1:2], 2'b00};
                if (req_write_en) begin
                    mem_we    = we_lo;
                    mem_wdata = wdata_lo;
                end
            end
        end
    end

    // Load data arrives from the SRAM in the response cycle, so extension is combinational
    always_comb begin
        load_data = load_valid ? ld_ext : '0;
    end

    // FSM, split-request latches and registered load response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_funct3    <= '0;
            lat_rd        <= '0;
            lat_load      <= 1'b0;
            resp_off      <= '0;
            resp_size     <= '0;
            resp_unsigned <= 1'b0;
            resp_split    <= 1'b0;
            lo_word       <= '0;
            load_valid    <= 1'b0;
            load_rd       <= '0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        if (req_mis) begin
                            state      <= ST_SECOND;
                            lat_addr   <= req_addr;
                            lat_data   <= req_write_data;
                            lat_funct3 <= req_funct3;
                            lat_rd     <= req_rd;
                            lat_load   <= ~req_write_en;
                        end else if (!req_write_en) begin
                            load_valid    <= 1'b1;
                            load_rd       <= req_rd;
                            resp_off      <= req_addr[1:0];
                            resp_size     <= req_size;
                            resp_unsigned <= req_funct3[2];
                            resp_split    <= 1'b0;
                        end
                    end
                end
                ST_SECOND: begin
                    state <= ST_IDLE;
                    if (lat_load) begin
                        load_valid    <= 1'b1;
                        load_rd       <= lat_rd;
                        resp_off      <= lat_addr[1:0];
                        resp_size     <= decode_size(lat_funct3);
                        resp_unsigned <= lat_funct3[2];
                        resp_split    <= 1'b1;
                        lo_word       <= mem_rdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: SRAM model, byte-level reference memory, spec vectors,
// hand-written split/reset/wrap sequences and randomized traffic.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_read_en;
    logic        req_write_en;
    logic [31:0] req_addr;
    logic [31:0] req_write_data;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        stall;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [31:0] load_data;

    lsu #(.XLEN(32), .REG_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_read_en    (req_read_en),
        .req_write_en   (req_write_en),
        .req_addr       (req_addr),
        .req_write_data (req_write_data),
        .req_funct3     (req_funct3),
        .req_rd         (req_rd),
        .stall          (stall),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .load_valid     (load_valid),
        .load_rd        (load_rd),
        .load_data      (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_t;
    resp_t exp_q [$];

    logic        s_en;
    logic [3:0]  s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    // Synchronous single-port SRAM with byte strobes
    always @(posedge clk) begin
        if (mem_en) begin
            logic [31:0] w;
            w = sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
            mem_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            if (mem_we != 4'b0000) sram[mem_addr] = w;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: gather bytes at consecutive addresses, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        int unsigned n;
        logic [31:0] v;
        n = nbytes(f);
        v = 32'h0;
        for (int unsigned i = 0; i < n; i++) v |= 32'(rbyte(a + i)) << (8 * i);
        if (!f[2] && n == 1 && v[7])  v |= 32'hFFFF_FF00;
        if (!f[2] && n == 2 && v[15]) v |= 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        for (int unsigned i = 0; i < nbytes(f); i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] waddr, input logic [31:0] word);
        sram[waddr] = word;
        for (int unsigned i = 0; i < 4; i++) ref_mem[waddr + i] = word[8*i +: 8];
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [4:0] rd);
        req_read_en = r; req_write_en = w; req_addr = a;
        req_write_data = d; req_funct3 = f; req_rd = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        @(negedge clk);
    endtask

    // Present a request (starting just after a negedge) until it is accepted, bounded
    task automatic send(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic [4:0] rd);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 4 && !done; t++) begin
            drive(r, w, a, d, f, rd);
            #1;
            if (!stall) begin
                done = 1'b1;
                s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
                if (w) ref_store(a, d, f);
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got stall=%b expected 0 within 4 cycles", stall);
        end
    endtask

    // Every returned load is matched against the expected-response queue
    always @(negedge clk) begin
        if (load_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_load_valid: got rd=%0d data=%h expected no response", load_rd, load_data);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("mon_load_rd", 32'(load_rd), 32'(e.rd));
                check("mon_load_data", load_data, e.data);
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
    } st_vec_t;

    ld_vec_t ld_vecs [7];
    st_vec_t st_vecs [5];
    logic [2:0] ld_f3s [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_vecs[0] = '{3'b010, 32'h100, 32'h8899AABB, 32'h8899AABB};
        ld_vecs[1] = '{3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80};
        ld_vecs[2] = '{3'b100, 32'h103, 32'h80112233, 32'h00000080};
        ld_vecs[3] = '{3'b001, 32'h102, 32'h80112233, 32'hFFFF8011};
        ld_vecs[4] = '{3'b101, 32'h102, 32'h80112233, 32'h00008011};
        ld_vecs[5] = '{3'b000, 32'h101, 32'h80112233, 32'h00000022};
        ld_vecs[6] = '{3'b001, 32'h101, 32'h44332211, 32'h00003322};

        st_vecs[0] = '{3'b001, 32'h202, 32'h1234ABCD, 32'h200, 4'b1100, 32'hABCD0000};
        st_vecs[1] = '{3'b000, 32'h201, 32'h000000EE, 32'h200, 4'b0010, 32'h0000EE00};
        st_vecs[2] = '{3'b010, 32'h204, 32'hCAFEF00D, 32'h204, 4'b1111, 32'hCAFEF00D};
        st_vecs[3] = '{3'b000, 32'h207, 32'h12345678, 32'h204, 4'b1000, 32'h78000000};
        st_vecs[4] = '{3'b001, 32'h205, 32'h0000BEEF, 32'h204, 4'b0110, 32'h00BEEF00};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd1);
        #1;
        check("rst_mem_en_gated", 32'(mem_en), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        rst_n = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_load_valid", 32'(load_valid), 32'h0);
        check("rst_load_rd", 32'(load_rd), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        @(negedge clk);

        // Aligned load vectors
        for (int i = 0; i < 7; i++) begin
            preload(ld_vecs[i].addr & ~32'h3, ld_vecs[i].word);
            exp_q.push_back('{5'(i + 5), ld_vecs[i].exp});
            send(1'b1, 1'b0, ld_vecs[i].addr, 32'h0, ld_vecs[i].f3, 5'(i + 5));
            check("ld_mem_en", 32'(s_en), 32'h1);
            check("ld_mem_we", 32'(s_we), 32'h0);
            check("ld_mem_addr", s_addr, ld_vecs[i].addr & ~32'h3);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
            #1;
            check("ld_valid_t1", 32'(load_valid), 32'h1);
            check("ld_rd_t1", 32'(load_rd), 32'(i + 5));
            check("ld_data_t1", load_data, ld_vecs[i].exp);
            @(negedge clk);
            #1;
            check("ld_valid_one_cycle", 32'(load_valid), 32'h0);
            @(negedge clk);
        end

        // Aligned store vectors
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 1'b1, st_vecs[i].addr, st_vecs[i].data, st_vecs[i].f3, 5'd3);
            check("st_mem_addr", s_addr, st_vecs[i].exp_addr);
            check("st_mem_we", 32'(s_we), 32'(st_vecs[i].exp_we));
            check("st_mem_wdata", s_wdata, st_vecs[i].exp_wdata);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
            #1;
            check("st_no_load_valid", 32'(load_valid), 32'h0);
            check("st_no_stall", 32'(stall), 32'h0);
            @(negedge clk);
        end

        // Misaligned LW 0x101
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        exp_q.push_back('{5'd7, 32'h55443322});
        drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 5'd7);
        #1;
        check("mlw_t0_addr", mem_addr, 32'h100);
        check("mlw_t0_stall", 32'(stall), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        #1;
        check("mlw_t1_stall", 32'(stall), 32'h1);
        check("mlw_t1_en", 32'(mem_en), 32'h1);
        check("mlw_t1_addr", mem_addr, 32'h104);
        check("mlw_t1_we", 32'(mem_we), 32'h0);
        check("mlw_t1_valid", 32'(load_valid), 32'h0);
        @(negedge clk);
        #1;
        check("mlw_t2_stall", 32'(stall), 32'h0);
        check("mlw_t2_valid", 32'(load_valid), 32'h1);
        check("mlw_t2_rd", 32'(load_rd), 32'd7);
        check("mlw_t2_data", load_data, 32'h55443322);
        @(negedge clk);

        // Misaligned SW 0x103 with a request held during the stall
        preload(32'h100, 32'h11111111);
        preload(32'h104, 32'h22222222);
        preload(32'h110, 32'h33333333);
        drive(1'b0, 1'b1, 32'h103, 32'hDDCCBBAA, 3'b010, 5'd0);
        #1;
        check("msw_t0_addr", mem_addr, 32'h100);
        check("msw_t0_we", 32'(mem_we), 32'b1000);
        check("msw_t0_lane3", 32'(mem_wdata[31:24]), 32'hAA);
        ref_store(32'h103, 32'hDDCCBBAA, 3'b010);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h110, 32'h00000055, 3'b000, 5'd0);
        #1;
        check("msw_t1_stall", 32'(stall), 32'h1);
        check("msw_t1_addr", mem_addr, 32'h104);
        check("msw_t1_we", 32'(mem_we), 32'b0111);
        check("msw_t1_lanes", 32'(mem_wdata[23:0]), 32'hDDCCBB);
        @(negedge clk);
        #1;
        check("msw_t2_stall", 32'(stall), 32'h0);
        check("msw_t2_addr", mem_addr, 32'h110);
        check("msw_t2_we", 32'(mem_we), 32'b0001);
        ref_store(32'h110, 32'h00000055, 3'b000);
        @(negedge clk);
        idle();
        check("msw_word0", sram[32'h100], 32'hAA111111);
        check("msw_word1", sram[32'h104], 32'h22DDCCBB);
        check("msw_word2", sram[32'h110], 32'h33333355);

        // Reset during the upper half of a split load
        preload(32'h120, 32'hA1A2A3A4);
        preload(32'h124, 32'hB1B2B3B4);
        drive(1'b1, 1'b0, 32'h122, 32'h0, 3'b010, 5'd3);
        #1;
        check("rsplit_t0_en", 32'(mem_en), 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        rst_n = 1'b0;
        #1;
        check("rsplit_no_upper", 32'(mem_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rsplit_no_valid", 32'(load_valid), 32'h0);
        check("rsplit_idle", 32'(stall), 32'h0);
        @(negedge clk);
        exp_q.push_back('{5'd4, 32'hA1A2A3A4});
        send(1'b1, 1'b0, 32'h120, 32'h0, 3'b010, 5'd4);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        #1;
        check("rsplit_after_valid", 32'(load_valid), 32'h1);
        check("rsplit_after_data", load_data, 32'hA1A2A3A4);
        @(negedge clk);

        // Address wrap on the upper half
        preload(32'hFFFF_FFFC, 32'h11223344);
        preload(32'h0000_0000, 32'h55667788);
        exp_q.push_back('{5'd9, 32'h77881122});
        drive(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 3'b010, 5'd9);
        #1;
        check("wrap_t0_addr", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
        #1;
        check("wrap_t1_addr", mem_addr, 32'h0);
        @(negedge clk);
        idle();

        // Randomized traffic against the byte-level reference
        for (int unsigned a = 32'h100; a <= 32'h144; a += 4) preload(a, $urandom);
        for (int n = 0; n < 300; n++) begin
            int unsigned kind;
            logic [31:0] a;
            logic [31:0] d;
            logic [2:0]  f;
            logic [4:0]  rd;
            kind = $urandom_range(0, 4);
            a    = 32'h100 + $urandom_range(0, 63);
            d    = $urandom;
            rd   = 5'($urandom_range(1, 31));
            if (kind == 4) begin
                idle();
            end else if (kind <= 1) begin
                f = ld_f3s[$urandom_range(0, 5)];
                exp_q.push_back('{rd, ref_load(a, f)});
                send(1'b1, 1'b0, a, d, f, rd);
            end else begin
                f = 3'($urandom_range(0, 3));
                send(kind == 3, 1'b1, a, d, f, rd);
            end
        end
        repeat (3) idle();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        for (int unsigned a = 32'h100; a <= 32'h144; a += 4)
            check("final_mem", sram.exists(a) ? sram[a] : 32'h0,
                  {rbyte(a + 3), rbyte(a + 2), rbyte(a + 1), rbyte(a)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the responder side of the execution stage's memory request interface (`mem_read_en`/`mem_write_en`, address, write data). It converts byte/half/word requests into word-wide accesses on a synchronous single-port data SRAM, generating byte strobes, splitting misaligned accesses into two word accesses, and returning sign- or zero-extended load data tagged with its destination register. It sits between `ex` and the data memory and raises a stall while a split access is in flight.

## Interface
- `XLEN`, 32: data/address width (`XLEN_WIDTH`).
- `REG_AW`, 5: register address width (`REG_ADDR`).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_read_en` in 1: load request.
- `req_write_en` in 1: store request.
- `req_addr` in 32: byte address.
- `req_write_data` in 32: store data, LSB-justified.
- `req_funct3` in 3: access size/sign (RV32I load/store funct3).
- `req_rd` in 5: load destination register.
- `stall` out 1: request inputs ignored this cycle; upstream must hold.
- `mem_en` out 1: SRAM access this cycle.
- `mem_we` out 4: byte write strobes; all zero = read.
- `mem_addr` out 32: word-aligned address (bits [1:0] = 0).
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after a read.
- `load_valid` out 1: load result valid.
- `load_rd` out 5: destination of the returned load.
- `load_data` out 32: extended load result.

## Operation
- Size from `req_funct3[1:0]`: 00 byte, 01 half, 10 word; 11 treated as word. Load `req_funct3[2]`=1 → zero-extend (LBU/LHU), else sign-extend.
- Both enables high: store wins, no load response.
- Offset `o = req_addr[1:0]`. Access misaligned iff half with o=3 or word with o≠0.
- Aligned: one SRAM cycle. `mem_addr = req_addr & ~3`; store strobes = size mask << o, `mem_wdata = req_write_data << 8*o`.
- Misaligned: lower word first (lanes o..3), then `mem_addr+4` (remaining low lanes); store data bytes routed to matching lanes in each half.
- FSM states: IDLE, SECOND.
  - IDLE → SECOND on accepted misaligned request; latch addr, data, funct3, rd, kind. Otherwise stay.
  - SECOND → IDLE unconditionally after issuing the upper access.
- Load result: select bytes from `mem_rdata` (and latched lower-word bytes for split loads), shift to LSB, extend per funct3.
- Stores produce no `load_valid`.

## Timing
- Reset values: state IDLE, `stall` 0, `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `load_valid` 0, `load_rd` 0, `load_data` 0, all latches 0.
- `mem_*` outputs combinational from request (IDLE) or latches (SECOND); `stall` = (state == SECOND).
- Aligned load accepted cycle T: SRAM read T, `load_valid`/`load_rd`/`load_data` registered, high in T+1 for exactly one cycle.
- Misaligned load accepted T: lower read T, `stall` high T+1 with upper read T+1, lower-word bytes captured at end of T+1, `load_valid` T+2.
- Misaligned store: writes at T and T+1; `stall` high in T+1.
- Back-to-back aligned requests: one per cycle, no bubbles.
- Requests present while `stall` high are not issued and not latched.
- Reset asserted mid-split: pending upper half dropped (no upper write, no `load_valid`), state IDLE next cycle.
- Address wrap: upper access of split at `0xFFFF_FFFC` goes to `0x0000_0000`.

## Structure
- Shared constants in `define/const.v`: size codes (`LSU_SIZE_B/H/W`), FSM state encodings. Load/store funct3 values in `define/inst.v` (`INST_FUNCT3_LB`…`INST_FUNCT3_SW`).
- One combinational sub-module `lsu_align`: given offset, size, sign and two 32-bit words, produces strobes, lane-shifted write data and extended load data; `lsu` holds FSM, latches and output registers.

## Test plan
- LW `0x100`, SRAM word `0x8899AABB`, rd=5 → `mem_we`=0000, `load_valid` next cycle, `load_rd`=5, `load_data`=`0x8899AABB`.
- LB `0x103` on word `0x80112233` → `0xFFFFFF80`; LBU same → `0x00000080`.
- SH `0x202`, data `0x1234ABCD` → `mem_addr`=`0x200`, `mem_we`=1100, `mem_wdata[31:16]`=`0xABCD`, no `load_valid`.
- LW `0x101`, words `0x100`=`0x44332211`, `0x104`=`0x88776655` → reads `0x100` then `0x104`, `stall` one cycle, `load_data`=`0x55443322` at T+2.
- SW `0x103`, data `0xDDCCBBAA` → T: `0x100` strobes 1000 lane3=`AA`; T+1: `0x104` strobes 0111 = `DDCCBB`; request presented during stall not issued.
- Misaligned load, `rst_n` low in T+1 → no upper access, `load_valid` stays 0, next aligned request served normally.
